// File: rtl/irq_ctrl.sv
// irq_ctrl: CHANNELS-source masked interrupt controller with toggle intr/vect handshake; define IRQ_ROTATE_EN for round-robin priority
module irq_ctrl #(
   parameter int CHANNELS  = 8,
   parameter int VECT_W    = 3,
   parameter int VECT_BASE = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] src,
   input  logic                we,
   input  logic [1:0]          sel,
   input  logic [7:0]          din,
   output logic [7:0]          dout,
   output logic                intr,
   output logic [VECT_W-1:0]   vect,
   output logic                busy
);
   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   logic [CHANNELS-1:0] mask, pending, pending_n, set_v, clr_v, wdat;
   logic [IW-1:0]       k;
   logic                disp;
`ifdef IRQ_ROTATE_EN
   logic [IW-1:0]       last;
   logic                found;
   int                  p;
`endif
   assign wdat = din[CHANNELS-1:0];
   assign disp = !busy && |pending;
   assign dout = sel == 2'd0 ? 8'(mask) : sel == 2'd1 ? 8'(pending) : sel == 2'd2 ? {busy, 7'(vect)} : 8'h00;
`ifdef IRQ_ROTATE_EN
   // pick the first pending channel after the last one served, wrapping round
   always_comb begin
      k = '0;
      found = 1'b0;
      p = 0;
      for (int j = 0; j < CHANNELS; j++) begin
         p = (int'(last) + 1 + j) % CHANNELS;
         if (!found && pending[IW'(p)]) begin
            k = IW'(p);
            found = 1'b1;
         end
      end
   end
`else
   // pick the lowest pending channel
   always_comb begin
      k = '0;
      for (int j = CHANNELS - 1; j >= 0; j--) if (pending[IW'(j)]) k = IW'(j);
   end
`endif
   // pending update: sets beat clears, a disabling mask write beats everything
   always_comb begin
      set_v = (src & mask) | ((we && sel == 2'd3) ? (wdat & mask) : '0);
      clr_v = (disp ? (CHANNELS'(1) << k) : '0) | ((we && sel == 2'd1) ? wdat : '0);
      pending_n = ((pending & ~clr_v) | set_v) & ((we && sel == 2'd0) ? wdat : '1);
   end
   // register state, dispatch and EOI
   always_ff @(posedge clock) begin
      if (reset) begin
         mask    <= '0;
         pending <= '0;
         busy    <= 1'b0;
         intr    <= 1'b0;
         vect    <= '0;
`ifdef IRQ_ROTATE_EN
         last    <= IW'(CHANNELS - 1);
`endif
      end else begin
         pending <= pending_n;
         if (we && sel == 2'd0) mask <= wdat;
         if (disp) begin
            busy <= 1'b1;
            intr <= ~intr;
            vect <= VECT_W'(VECT_BASE + int'(k));
`ifdef IRQ_ROTATE_EN
            last <= k;
`endif
         end else if (we && sel == 2'd2) begin
            busy <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: vector table, reset-in-service sequence and randomized run against a rule-level model
module tb_irq_ctrl;
   logic       clock, reset, we, intr, busy;
   logic [7:0] src, din, dout;
   logic [1:0] sel;
   logic [2:0] vect;
   int         n_tests = 0, n_fail = 0;
   logic [7:0] m_mask, m_pend;
   logic       m_busy, m_intr;
   logic [2:0] m_vect;
   int         m_last;

   typedef struct {
      logic [7:0] src;
      logic       we;
      logic [1:0] sel;
      logic [7:0] din;
      logic [7:0] pend;
      logic       busy;
      logic       intr;
      logic [2:0] vect;
   } vec_t;
   vec_t tbl[37];

   irq_ctrl dut (.clock(clock), .reset(reset), .src(src), .we(we), .sel(sel), .din(din),
                 .dout(dout), .intr(intr), .vect(vect), .busy(busy));

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mask = 0; m_pend = 0; m_busy = 0; m_intr = 0; m_vect = 0; m_last = 7;
   endtask

   task automatic model_edge(input logic [7:0] s, input logic w, input logic [1:0] sl, input logic [7:0] d);
      int k = -1;
      int start = 0;
      logic [7:0] np;
`ifdef IRQ_ROTATE_EN
      start = (m_last + 1) % 8;
`endif
      if (!m_busy && m_pend != 0)
         for (int j = 0; j < 8; j++) if (k < 0 && m_pend[(start + j) % 8]) k = (start + j) % 8;
      for (int i = 0; i < 8; i++) begin
         bit setb = m_mask[i] && (s[i] || (w && sl == 2'd3 && d[i]));
         bit clrb = (i == k) || (w && sl == 2'd1 && d[i]);
         bit v = setb ? 1'b1 : clrb ? 1'b0 : m_pend[i];
         if (w && sl == 2'd0 && !d[i]) v = 1'b0;
         np[i] = v;
      end
      m_pend = np;
      if (w && sl == 2'd0) m_mask = d;
      if (k >= 0) begin
         m_busy = 1; m_intr = !m_intr; m_vect = 3'((1 + k) % 8); m_last = k;
      end else if (w && sl == 2'd2) m_busy = 0;
   endtask

   task automatic step(input logic [7:0] s, input logic w, input logic [1:0] sl, input logic [7:0] d);
      src = s; we = w; sel = sl; din = d;
      model_edge(s, w, sl, d);
      @(posedge clock);
      #1;
      src = 0; we = 0; din = 0;
   endtask

   function automatic logic [7:0] model_dout(input int s);
      return s == 0 ? m_mask : s == 1 ? m_pend : s == 2 ? {m_busy, 4'b0, m_vect} : 8'h00;
   endfunction

   task automatic check_model(input string tag);
      chk($sformatf("%s intr", tag), 8'(intr), 8'(m_intr));
      chk($sformatf("%s busy", tag), 8'(busy), 8'(m_busy));
      chk($sformatf("%s vect", tag), 8'(vect), 8'(m_vect));
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         chk($sformatf("%s dout sel%0d", tag, s), dout, model_dout(s));
      end
   endtask

   initial begin
      tbl[0]  = '{8'h00, 1, 2'd0, 8'h03, 8'h00, 0, 0, 3'd0};
      tbl[1]  = '{8'h02, 0, 2'd0, 8'h00, 8'h02, 0, 0, 3'd0};
      tbl[2]  = '{8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 1, 3'd2};
      tbl[3]  = '{8'h01, 0, 2'd0, 8'h00, 8'h01, 1, 1, 3'd2};
      tbl[4]  = '{8'h00, 1, 2'd2, 8'h00, 8'h01, 0, 1, 3'd2};
      tbl[5]  = '{8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 0, 3'd1};
      tbl[6]  = '{8'h00, 1, 2'd2, 8'h00, 8'h00, 0, 0, 3'd1};
      tbl[7]  = '{8'h00, 1, 2'd0, 8'h00, 8'h00, 0, 0, 3'd1};
      tbl[8]  = '{8'hFF, 0, 2'd0, 8'h00, 8'h00, 0, 0, 3'd1};
      tbl[9]  = '{8'h00, 1, 2'd0, 8'h0F, 8'h00, 0, 0, 3'd1};
      tbl[10] = '{8'h00, 1, 2'd3, 8'hF0, 8'h00, 0, 0, 3'd1};
      tbl[11] = '{8'h00, 1, 2'd0, 8'hFF, 8'h00, 0, 0, 3'd1};
      tbl[12] = '{8'h00, 1, 2'd3, 8'h80, 8'h80, 0, 0, 3'd1};
      tbl[13] = '{8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 1, 3'd0};
      tbl[14] = '{8'h30, 0, 2'd0, 8'h00, 8'h30, 1, 1, 3'd0};
      tbl[15] = '{8'h00, 1, 2'd1, 8'h10, 8'h20, 1, 1, 3'd0};
      tbl[16] = '{8'h20, 1, 2'd1, 8'h20, 8'h20, 1, 1, 3'd0};
      tbl[17] = '{8'h00, 1, 2'd2, 8'h00, 8'h20, 0, 1, 3'd0};
      tbl[18] = '{8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 0, 3'd6};
      tbl[19] = '{8'h00, 1, 2'd2, 8'h00, 8'h00, 0, 0, 3'd6};
      tbl[20] = '{8'h00, 1, 2'd0, 8'h05, 8'h00, 0, 0, 3'd6};
      tbl[21] = '{8'h05, 0, 2'd0, 8'h00, 8'h05, 0, 0, 3'd6};
      tbl[22] = '{8'h00, 0, 2'd0, 8'h00, 8'h04, 1, 1, 3'd1};
      tbl[23] = '{8'h00, 1, 2'd2, 8'h00, 8'h04, 0, 1, 3'd1};
      tbl[24] = '{8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 0, 3'd3};
      tbl[25] = '{8'h00, 1, 2'd2, 8'h00, 8'h00, 0, 0, 3'd3};
      tbl[26] = '{8'h05, 1, 2'd0, 8'h01, 8'h01, 0, 0, 3'd3};
      tbl[27] = '{8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 1, 3'd1};
      tbl[28] = '{8'h01, 1, 2'd2, 8'h00, 8'h01, 0, 1, 3'd1};
      tbl[29] = '{8'h00, 1, 2'd0, 8'h00, 8'h00, 1, 0, 3'd1};
      tbl[30] = '{8'h00, 1, 2'd2, 8'h00, 8'h00, 0, 0, 3'd1};
      tbl[31] = '{8'h00, 1, 2'd0, 8'h02, 8'h00, 0, 0, 3'd1};
      tbl[32] = '{8'h02, 0, 2'd0, 8'h00, 8'h02, 0, 0, 3'd1};
      tbl[33] = '{8'h02, 0, 2'd0, 8'h00, 8'h02, 1, 1, 3'd2};
      tbl[34] = '{8'h00, 1, 2'd2, 8'h00, 8'h02, 0, 1, 3'd2};
      tbl[35] = '{8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 0, 3'd2};
      tbl[36] = '{8'h00, 1, 2'd2, 8'h00, 8'h00, 0, 0, 3'd2};

      reset = 1; src = 0; we = 0; sel = 0; din = 0;
      @(posedge clock);
      #1;
      reset = 0;
      model_reset();
      chk("reset intr", 8'(intr), 8'h00);
      chk("reset busy", 8'(busy), 8'h00);
      chk("reset vect", 8'(vect), 8'h00);

      for (int i = 0; i < 37; i++) begin
         step(tbl[i].src, tbl[i].we, tbl[i].sel, tbl[i].din);
         sel = 2'd1;
         #1;
         chk($sformatf("vec%0d pending", i), dout, tbl[i].pend);
         chk($sformatf("vec%0d busy", i), 8'(busy), 8'(tbl[i].busy));
         chk($sformatf("vec%0d intr", i), 8'(intr), 8'(tbl[i].intr));
         chk($sformatf("vec%0d vect", i), 8'(vect), 8'(tbl[i].vect));
      end

      step(8'h00, 1, 2'd0, 8'hFF);
      step(8'h01, 0, 2'd0, 8'h00);
      step(8'h00, 0, 2'd0, 8'h00);
      step(8'h0C, 0, 2'd0, 8'h00);
      check_model("pre-reset");
      reset = 1;
      @(posedge clock);
      #1;
      reset = 0;
      model_reset();
      chk("midreset intr", 8'(intr), 8'h00);
      chk("midreset busy", 8'(busy), 8'h00);
      chk("midreset vect", 8'(vect), 8'h00);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         #1;
         chk($sformatf("midreset dout sel%0d", s), dout, 8'h00);
      end

      for (int i = 0; i < 400; i++) begin
         logic [7:0] rs;
         logic       rw;
         rs = 8'($urandom) & 8'($urandom);
         rw = ($urandom_range(0, 3) == 0);
         step(rs, rw, 2'($urandom_range(0, 3)), 8'($urandom));
         check_model($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Parametrised interrupt controller for the AVR core. It generalises the two-source timer/keyboard interrupt queue into CHANNELS sources, each with a mask bit, a pending latch and fixed-priority dispatch. It presents the core's toggle-style intr/vect interface and a small 4-register port window, which the top level decodes from the I/O address map.

Parameters:
CHANNELS, 8, number of interrupt sources; legal range 1..8.
VECT_W, 3, width of the vect output.
VECT_BASE, 1, vector number of channel 0; channel i maps to (VECT_BASE+i) mod 2^VECT_W.

Ports:
clock  in  1  system clock (CPU clock domain)
reset  in  1  synchronous reset, active-high
src  in  CHANNELS  event strobes, one-cycle pulse per event; bit i = channel i
we  in  1  register write strobe
sel  in  2  register select: 0 MASK, 1 PENDING, 2 STATUS/EOI, 3 FORCE
din  in  8  write data
dout  out  8  read data for sel; combinational
intr  out  1  toggles once per dispatched interrupt (core detects the edge)
vect  out  VECT_W  vector of the interrupt currently in service
busy  out  1  1 = an interrupt is in service and awaiting EOI

Behaviour:
- Reset: mask=0, pending=0, busy=0, intr=0, vect=0. Reset mid-service discards all pending and in-service state.
- Register bits above CHANNELS-1 read as 0 and ignore writes.
- MASK (sel 0), r/w: bit i=1 enables channel i. Writing mask also clears pending bits whose new mask bit is 0 (pending &= new_mask).
- PENDING (sel 1): read returns the pending vector. Writing clears every pending bit whose din bit is 1 (write-1-to-clear).
- STATUS (sel 2): read returns {busy, 7-VECT_W zero bits, vect}. Any write is EOI and sets busy to 0.
- FORCE (sel 3), write-only, reads 0: sets pending[i] for each din[i]=1 with mask[i]=1 (software interrupt).
- Event latch: src[i]=1 at edge t with mask[i]=1 gives pending[i]=1 after edge t. Events on a masked channel are dropped, not remembered.
- Dispatch: at any edge where busy=0 and pending!=0, the controller selects the lowest set index k (channel 0 is highest priority). In that same edge it clears pending[k], loads vect to VECT_BASE+k, sets busy to 1 and inverts intr.
- Latency: src pulse at edge t produces a dispatch at edge t+1 when idle.
- EOI at edge e gives busy=0 after e; the earliest next dispatch is edge e+1, so there is at least one idle cycle between services.
- One event per channel is queued. Repeat events on a channel that is already pending merge into that single pending bit. A channel in service may re-pend and is dispatched again after EOI.
- Simultaneous events on the same pending bit: setting beats clearing. A src or FORCE set in the same cycle as a dispatch-clear or W1C-clear of that bit leaves the bit at 1. A MASK write disabling the channel beats everything.
- A MASK write and a dispatch in the same cycle: dispatch uses the mask value from before the edge.
- While busy=1, vect and intr are held stable.

Optional Feature:
IRQ_ROTATE_EN:
- With the macro defined, priority rotates. A last-served index register (reset value CHANNELS-1) is kept, and dispatch selects the first pending index searching upward from last+1 with wrap-around. This is round-robin, so no channel can starve.
- Without the macro, fixed priority applies and the lowest index always wins.
- The register map and timing are identical in both builds.

Test Plan:
1. Reset, write MASK=0x03, pulse src=0x02 at t: pending=0x02 after t; at t+1 intr 0->1, vect=2, busy=1, pending=0x00.
2. While busy, pulse src[0], then write STATUS (EOI) at edge e: busy=0 after e; at e+1 intr toggles to 0, vect=1.
3. MASK=0x00, pulse src=0xFF: pending stays 0x00, intr unchanged. Then MASK=0x0F and FORCE=0xF0: pending stays 0x00.
4. MASK=0xFF, busy=1, pulse src=0x30, then write PENDING=0x10: pending=0x20. Next, in a single cycle, pulse src[5] and write PENDING=0x20: pending=0x20 (set wins).
5. MASK=0x05, src=0x05 in the same cycle: first dispatch is vect=1. After EOI, the next is vect=3. With IRQ_ROTATE_EN, repeating both events after the second EOI gives vect=1 then 3 in alternation: the last-served index was 2 and the search wraps to 0.
6. Assert reset while busy=1 and pending=0x0C: after the edge, mask=0, pending=0, busy=0, intr=0, vect=0, dout=0 for all sel values.
